// File: rtl/apb_pkg.sv
// Shared definitions for the APB completer: bus widths, address field
// positions, request payload and FSM state encoding.
package apb_pkg;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned PORT_MSB = 7;
  localparam int unsigned PORT_LSB = 6;
  localparam int unsigned CNT_W    = 4;

  typedef logic [1:0]        sel_bit;
  typedef logic [ADDR_W-1:0] add_bit;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_slv_state_e;

  // Transfer captured during SETUP; ACCESS-phase bus values are never used.
  typedef struct packed {
    logic              wr;
    add_bit            addr;
    logic [DATA_W-1:0] data;
  } apb_req_t;

  // Index width for a given word count (at least one bit).
  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_W word store with synchronous write, registered read port and
// synchronous clear on rst.
//   clk, rst   : clock, synchronous active-high reset (clears all words)
//   i_we       : write i_wdata to word i_idx
//   i_re       : load word i_idx into the read register
//   i_err      : force the read register to zero (error response)
//   i_idx      : word index, caller guarantees i_idx < DEPTH when i_we/i_re
//   i_wdata    : write data
//   o_rd_data  : read register, holds between loads
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic              i_err,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Storage and read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[IDX_W'(i)] <= '0;
      end
      r_rd_data <= '0;
    end else begin
      if (i_we) begin
        r_mem[i_idx] <= i_wdata;
      end
      if (i_err) begin
        r_rd_data <= '0;
      end else if (i_re) begin
        r_rd_data <= r_mem[i_idx];
      end
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer in front of a word register file. Captures the request in
// SETUP, waits WAIT_CYCLES extra ACCESS cycles, then completes with a one-cycle
// ready pulse; out-of-port or out-of-depth addresses answer with slverr.
//   clk, rst  : clock, synchronous active-high reset
//   sel, en   : APB select and enable (en=1 is the ACCESS phase)
//   wr_in     : 1 = write, 0 = read
//   addr_in   : [7:6] port number, [5:0] word index
//   data_in   : write data
//   ready     : transfer complete pulse
//   data_out  : read data, valid with ready and held afterwards
//   slverr    : error response, valid with ready
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter sel_bit      SLAVE_ID    = 2'd0,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              en,
  input  logic              wr_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic [DATA_W-1:0] data_out,
  output logic              slverr
);

  localparam int unsigned IDX_W = idx_w(DEPTH);

  apb_slv_state_e   r_state, w_state_nxt;
  apb_req_t         r_req, w_req_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ready, w_ready_nxt;
  logic             r_slverr, w_slverr_nxt;
  logic             w_err;
  logic             w_we, w_re, w_rd_clr;
  apb_req_t         w_bus_req;

  assign w_bus_req = '{wr: wr_in, addr: addr_in, data: data_in};

  // Error decode on the captured address; index compared with a spare bit so DEPTH=64 fits.
  assign w_err = (r_req.addr[PORT_MSB:PORT_LSB] != SLAVE_ID) ||
                 ({1'b0, r_req.addr[PORT_LSB-1:0]} >= 7'(DEPTH));

  // State, request, counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_req    <= '0;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_slverr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_req    <= w_req_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ready  <= w_ready_nxt;
      r_slverr <= w_slverr_nxt;
    end
  end

  // Next-state and completion strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = r_req;
    w_cnt_nxt    = r_cnt;
    w_ready_nxt  = 1'b0;
    w_slverr_nxt = 1'b0;
    w_we         = 1'b0;
    w_re         = 1'b0;
    w_rd_clr     = 1'b0;
    unique case (r_state)
      IDLE: begin
        // sel with en already high is a protocol error and is ignored
        if (sel && !en) begin
          w_req_nxt   = w_bus_req;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (!sel) begin
          w_state_nxt = IDLE;
        end else if (en) begin
          w_cnt_nxt   = CNT_W'(WAIT_CYCLES);
          w_state_nxt = ACCESS;
        end else begin
          w_req_nxt = w_bus_req;
        end
      end
      ACCESS: begin
        if (!sel) begin
          w_state_nxt = IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_ready_nxt  = 1'b1;
          w_slverr_nxt = w_err;
          w_we         = r_req.wr && !w_err;
          w_re         = !r_req.wr && !w_err;
          w_rd_clr     = w_err;
          w_state_nxt  = RESP;
        end
      end
      RESP: begin
        // back-to-back: the ready cycle doubles as the next setup phase
        if (sel && !en) begin
          w_req_nxt   = w_bus_req;
          w_state_nxt = SETUP;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  apb_slave_regfile #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we),
    .i_re      (w_re),
    .i_err     (w_rd_clr),
    .i_idx     (r_req.addr[IDX_W-1:0]),
    .i_wdata   (r_req.data),
    .o_rd_data (data_out)
  );

  assign ready  = r_ready;
  assign slverr = r_slverr;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem. Two instances share the bus: u0 with
// SLAVE_ID=1, DEPTH=32, WAIT_CYCLES=1 and u1 with SLAVE_ID=1, DEPTH=64,
// WAIT_CYCLES=0. Inputs change and outputs are sampled on the falling edge.
module tb_apb_slave_mem;
  import apb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel0, sel1, en, wr;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        ready0, ready1, err0, err1;
  logic [31:0] dout0, dout1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_slave_mem #(.SLAVE_ID(2'd1), .DEPTH(32), .WAIT_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .sel(sel0), .en(en), .wr_in(wr), .addr_in(addr),
    .data_in(wdata), .ready(ready0), .data_out(dout0), .slverr(err0));

  apb_slave_mem #(.SLAVE_ID(2'd1), .DEPTH(64), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .sel(sel1), .en(en), .wr_in(wr), .addr_in(addr),
    .data_in(wdata), .ready(ready1), .data_out(dout1), .slverr(err1));

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // One APB transfer. b2b: start in the current cycle (previous ready cycle);
  // keep: leave sel high after ready for a following back-to-back transfer.
  // waits counts ready=0 cycles after the slave has entered ACCESS.
  task automatic xfer(input bit which, input bit b2b, input bit keep,
                      input logic w, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int waits,
                      output bit got, output int rcyc);
    if (!b2b) @(negedge clk);
    if (which) sel1 = 1'b1; else sel0 = 1'b1;
    en = 1'b0; wr = w; addr = a; wdata = d;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    // bus values during ACCESS must be ignored
    addr = ~a; wdata = ~d;
    got = 1'b0; waits = 0; rd = '0; er = 1'b0; rcyc = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      if ((which ? ready1 : ready0) === 1'b1) begin
        got  = 1'b1;
        rd   = which ? dout1 : dout0;
        er   = which ? err1 : err0;
        rcyc = cyc;
      end else begin
        waits++;
        @(negedge clk);
      end
    end
    en = 1'b0;
    if (!keep) begin
      sel0 = 1'b0;
      sel1 = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          waits, rcyc, prev, seen, nz;
    bit          got;
    logic [31:0] b2b_data [3];

    vecs[0]  = '{1'b0, 8'h45, 32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b1, 8'h45, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 8'h45, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 8'h7F, 32'hAAAA5555, 32'h0,        1'b1};
    vecs[4]  = '{1'b0, 8'h5F, 32'h0,        32'h0,        1'b0};
    vecs[5]  = '{1'b0, 8'h45, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[6]  = '{1'b0, 8'h85, 32'h0,        32'h0,        1'b1};
    vecs[7]  = '{1'b1, 8'h85, 32'h11111111, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 8'h45, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[9]  = '{1'b1, 8'h43, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0};
    vecs[10] = '{1'b1, 8'h5F, 32'h31313131, 32'hDEADBEEF, 1'b0};
    vecs[11] = '{1'b0, 8'h5F, 32'h0,        32'h31313131, 1'b0};
    vecs[12] = '{1'b0, 8'h60, 32'h0,        32'h0,        1'b1};
    vecs[13] = '{1'b0, 8'h05, 32'h0,        32'h0,        1'b1};

    rst = 1'b1; sel0 = 1'b0; sel1 = 1'b0; en = 1'b0; wr = 1'b0;
    addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(ready0), 32'd0);
    check("reset_slverr", 32'(err0), 32'd0);
    check("reset_data", dout0, 32'd0);
    check("reset_state", 32'(u0.r_state), 32'(IDLE));
    rst = 1'b0;

    // Table-driven transfers on u0 (one wait state).
    for (int i = 0; i < 14; i++) begin
      xfer(1'b0, 1'b0, 1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, waits, got, rcyc);
      check($sformatf("vec%0d_ready", i), 32'(got), 32'd1);
      check($sformatf("vec%0d_waits", i), 32'(waits), 32'd2);
      check($sformatf("vec%0d_slverr", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
      @(negedge clk);
      check($sformatf("vec%0d_pulse", i), 32'(ready0), 32'd0);
    end

    // Abort: drop sel while the write to 8'h43 is in ACCESS.
    @(negedge clk);
    sel0 = 1'b1; en = 1'b0; wr = 1'b1; addr = 8'h43; wdata = 32'h12345678;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    sel0 = 1'b0; en = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (ready0 === 1'b1) seen++;
    end
    check("abort_no_ready", 32'(seen), 32'd0);
    xfer(1'b0, 1'b0, 1'b0, 1'b0, 8'h43, 32'h0, rd, er, waits, got, rcyc);
    check("abort_readback", rd, 32'hCAFEF00D);
    check("abort_readback_err", 32'(er), 32'd0);

    // Back-to-back writes on u1 (no wait states), sel held high.
    b2b_data[0] = 32'hA1A1A1A1;
    b2b_data[1] = 32'hB2B2B2B2;
    b2b_data[2] = 32'hC3C3C3C3;
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      xfer(1'b1, (i != 0), (i != 2), 1'b1, 8'h40 + 8'(i), b2b_data[i], rd, er, waits, got, rcyc);
      check($sformatf("b2b%0d_ready", i), 32'(got), 32'd1);
      check($sformatf("b2b%0d_waits", i), 32'(waits), 32'd1);
      if (i != 0) check($sformatf("b2b%0d_spacing", i), 32'(rcyc - prev), 32'd3);
      prev = rcyc;
    end
    for (int i = 0; i < 3; i++) begin
      xfer(1'b1, 1'b0, 1'b0, 1'b0, 8'h40 + 8'(i), 32'h0, rd, er, waits, got, rcyc);
      check($sformatf("b2b%0d_readback", i), rd, b2b_data[i]);
    end

    // Reset while u0's counter is still non-zero.
    @(negedge clk);
    sel0 = 1'b1; en = 1'b0; wr = 1'b1; addr = 8'h46; wdata = 32'h55555555;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("midrst_pre_ready", 32'(ready0), 32'd0);
    rst = 1'b1; sel0 = 1'b0; en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", 32'(ready0), 32'd0);
    check("midrst_state", 32'(u0.r_state), 32'(IDLE));
    check("midrst_data", dout0, 32'd0);
    nz = 0;
    for (int i = 0; i < 32; i++) begin
      if (u0.u_rf.r_mem[i] !== 32'd0) nz++;
    end
    check("midrst_mem_clear", 32'(nz), 32'd0);
    xfer(1'b0, 1'b0, 1'b0, 1'b0, 8'h45, 32'h0, rd, er, waits, got, rcyc);
    check("midrst_read45", rd, 32'd0);
    xfer(1'b0, 1'b0, 1'b0, 1'b0, 8'h46, 32'h0, rd, er, waits, got, rcyc);
    check("midrst_read46", rd, 32'd0);
    check("midrst_read46_ready", 32'(got), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
